serial_adder: RTL

- Bit-serial adder of two WIDTH-bit operands.
- Reuses the existing 1-bit full_adder cell once per clock, LSB first, with a registered carry between bits.
- Sits directly around the full_adder stage: it feeds A/B/cin bit by bit, then collects each sum bit and the final carry-out into a parallel result.
- Serves as the sequential datapath exercise that follows the combinational adder lab.

---
 rtl/serial_adder_pkg.sv | 20 ++
 rtl/full_adder.sv | 21 ++
 rtl/serial_adder.sv | 120 ++++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// ============================================================================
// Module  : serial_adder_pkg
// Purpose : Shared state encodings and default width for the serial adder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/full_adder.sv
// ============================================================================
// Module  : full_adder
// Purpose : 1-bit combinational full adder, used as the serial bit-slice ALU.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

`default_nettype wire

// File: rtl/serial_adder.sv
// ============================================================================
// Module  : serial_adder
// Purpose : Bit-serial WIDTH-bit adder, LSB first, one full_adder per clock.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic             load;
    logic             last_bit;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] s_sr;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             fa_sum;
    logic             fa_cout;

    full_adder u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // DONE accepts a new start exactly like IDLE so operations can run back to back.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (cnt == LAST_CNT) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = S_RUN;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign last_bit = (state == S_RUN) && (cnt == LAST_CNT);
    assign busy     = (state == S_RUN);
    assign done     = (state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr  <= '0;
            b_sr  <= '0;
            s_sr  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (load) begin
            a_sr  <= a_in;
            b_sr  <= b_in;
            carry <= cin;
            cnt   <= '0;
        end else if (state == S_RUN) begin
            a_sr  <= a_sr >> 1;
            b_sr  <= b_sr >> 1;
            s_sr  <= {fa_sum, s_sr[WIDTH-1:1]};
            carry <= fa_cout;
            cnt   <= last_bit ? '0 : cnt + CNT_W'(1);
            // Publish the result including the bit being added on this edge.
            if (last_bit) begin
                sum  <= {fa_sum, s_sr[WIDTH-1:1]};
                cout <= fa_cout;
            end
        end
    end

endmodule

`default_nettype wire
